// File: rtl/mult_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : mult_sequencer_if
//  Brief    : Request/response bundle between the pipeline and the
//             sequential HI/LO multiplier (issue, HI/LO moves, status).
//  Revision : 1.0 - initial release
// ============================================================================
interface mult_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             mfhi;
  logic             mflo;
  logic             mthi;
  logic             mtlo;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] rdata;
  logic             busy;
  logic             stall;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  // Pipeline side: issues requests, observes status and results
  modport master (
    output start, is_signed, op_a, op_b, mfhi, mflo, mthi, mtlo, wdata,
    input  rdata, busy, stall, done, hi, lo
  );

  // Multiplier side
  modport slave (
    input  start, is_signed, op_a, op_b, mfhi, mflo, mthi, mtlo, wdata,
    output rdata, busy, stall, done, hi, lo
  );
endinterface
`default_nettype wire

// File: rtl/mult_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : mult_sequencer
//  Brief    : Radix-2 shift-add multiplier owning the HI/LO register pair.
//             WIDTH iterations per multiply plus one write-back cycle; signed
//             operands are multiplied as magnitudes and the product is
//             negated at write-back when the operand signs differ.
//  Revision : 1.0 - initial release
// ============================================================================
module mult_sequencer #(
  parameter int WIDTH = 32
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  mult_sequencer_if.slave   bus
);

  localparam int                 CNT_W     = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0]   LAST_ITER = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t             state_q;
  logic [2*WIDTH-1:0] mcand_q;   // multiplicand, shifted left each iteration
  logic [WIDTH-1:0]   mplier_q;  // multiplier, shifted right each iteration
  logic [2*WIDTH-1:0] acc_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               neg_q;     // product must be negated at write-back
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               done_q;

  logic [WIDTH-1:0]   mag_a_d;
  logic [WIDTH-1:0]   mag_b_d;
  logic               neg_d;
  logic [2*WIDTH-1:0] acc_d;
  logic [2*WIDTH-1:0] result_d;

  // Operand magnitudes; the most negative value maps to 2^(WIDTH-1) as an
  // unsigned quantity, so no overflow handling is needed.
  assign mag_a_d  = (bus.is_signed && bus.op_a[WIDTH-1]) ? (~bus.op_a + 1'b1) : bus.op_a;
  assign mag_b_d  = (bus.is_signed && bus.op_b[WIDTH-1]) ? (~bus.op_b + 1'b1) : bus.op_b;
  assign neg_d    = bus.is_signed & (bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1]);
  assign acc_d    = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
  assign result_d = neg_q ? (~acc_q + 1'b1) : acc_q;

  // Sequencer FSM with HI/LO write-back, moves and the done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            // A move in the same cycle as start is dropped
            mcand_q  <= {{WIDTH{1'b0}}, mag_a_d};
            mplier_q <= mag_b_d;
            neg_q    <= neg_d;
            acc_q    <= '0;
            cnt_q    <= '0;
            state_q  <= S_RUN;
          end else begin
            if (bus.mthi) hi_q <= bus.wdata;
            if (bus.mtlo) lo_q <= bus.wdata;
          end
        end
        S_RUN: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == LAST_ITER) state_q <= S_FIN;
        end
        S_FIN: begin
          {hi_q, lo_q} <= result_d;
          done_q       <= 1'b1;
          state_q      <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.busy  = (state_q != S_IDLE);
  assign bus.stall = bus.busy & (bus.start | bus.mfhi | bus.mflo | bus.mthi | bus.mtlo);
  assign bus.done  = done_q;
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;
  assign bus.rdata = bus.mfhi ? hi_q : (bus.mflo ? lo_q : '0);

endmodule
`default_nettype wire

// File: tb/tb_mult_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mult_sequencer
//  Brief    : Randomized self-checking bench for mult_sequencer; expected
//             HI/LO come from a plain-arithmetic product model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mult_sequencer;
  localparam int WIDTH = 32;

  logic clk = 1'b0;
  logic rst_n;
  int   vectors = 0;
  int   miscompares = 0;
  logic [WIDTH-1:0] m_hi, m_lo;   // model of HI/LO

  always #5 clk = ~clk;

  mult_sequencer_if #(.WIDTH(WIDTH)) bus ();
  mult_sequencer #(.WIDTH(WIDTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  // Full-width product from ordinary arithmetic
  function automatic logic [2*WIDTH-1:0] ref_prod(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b,
                                                  input logic s);
    logic signed [2*WIDTH-1:0] sa, sb;
    if (s) begin
      sa = {{WIDTH{a[WIDTH-1]}}, a};
      sb = {{WIDTH{b[WIDTH-1]}}, b};
      return sa * sb;
    end
    return {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
  endfunction

  function automatic logic [WIDTH-1:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return {{(WIDTH-1){1'b0}}, 1'b1};
      2: return '1;
      3: return {1'b1, {(WIDTH-1){1'b0}}};
      default: return $urandom;
    endcase
  endfunction

  // Drive one start at the current negedge; returns in busy cycle 1
  task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic s);
    bus.start = 1'b1; bus.op_a = a; bus.op_b = b; bus.is_signed = s;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Follow an operation from busy cycle 'first' through the done cycle,
  // scrambling operands while running; ends in the done cycle.
  task automatic test_completion(input string tag, input int first, input logic [2*WIDTH-1:0] prod);
    for (int i = first; i <= WIDTH + 1; i++) begin
      bus.op_a = $urandom; bus.op_b = $urandom; bus.is_signed = 1'($urandom);
      #1;
      vectors++;
      if (bus.busy !== 1'b1) begin
        miscompares++; $display("FAIL %s busy@%0d: got %b want 1", tag, i, bus.busy);
      end
      vectors++;
      if (bus.done !== 1'b0) begin
        miscompares++; $display("FAIL %s done@%0d: got %b want 0", tag, i, bus.done);
      end
      vectors++;
      if (bus.hi !== m_hi || bus.lo !== m_lo) begin
        miscompares++;
        $display("FAIL %s hold@%0d: got %h_%h want %h_%h", tag, i, bus.hi, bus.lo, m_hi, m_lo);
      end
      @(negedge clk);
    end
    #1;
    m_hi = prod[2*WIDTH-1:WIDTH];
    m_lo = prod[WIDTH-1:0];
    vectors++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b1) begin
      miscompares++; $display("FAIL %s end: got busy=%b done=%b want busy=0 done=1", tag, bus.busy, bus.done);
    end
    vectors++;
    if (bus.hi !== m_hi || bus.lo !== m_lo) begin
      miscompares++; $display("FAIL %s result: got %h_%h want %h_%h", tag, bus.hi, bus.lo, m_hi, m_lo);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start = 0; bus.is_signed = 0; bus.op_a = '0; bus.op_b = '0;
    bus.mfhi = 1; bus.mflo = 0; bus.mthi = 0; bus.mtlo = 0; bus.wdata = '0;
    repeat (3) @(negedge clk);
    #1;
    vectors++;
    if (bus.busy !== 0 || bus.stall !== 0 || bus.done !== 0) begin
      miscompares++; $display("FAIL reset_status: got busy=%b stall=%b done=%b want 0", bus.busy, bus.stall, bus.done);
    end
    vectors++;
    if (bus.hi !== '0 || bus.lo !== '0 || bus.rdata !== '0) begin
      miscompares++; $display("FAIL reset_regs: got %h_%h rdata=%h want 0", bus.hi, bus.lo, bus.rdata);
    end
    m_hi = '0; m_lo = '0;
    @(negedge clk);
    bus.mfhi = 0;
    rst_n = 1'b1;
  endtask

  task automatic test_moves();
    logic [WIDTH-1:0] v;
    logic [WIDTH-1:0] a, b;
    @(negedge clk);
    v = $urandom; bus.mthi = 1; bus.wdata = v;
    #1;
    vectors++;
    if (bus.stall !== 1'b0) begin
      miscompares++; $display("FAIL idle_stall: got %b want 0", bus.stall);
    end
    @(negedge clk);
    bus.mthi = 0; m_hi = v;
    v = $urandom; bus.mtlo = 1; bus.wdata = v;
    @(negedge clk);
    bus.mtlo = 0; m_lo = v;
    bus.mfhi = 1; bus.mflo = 1; #1;
    vectors++;
    if (bus.rdata !== m_hi) begin
      miscompares++; $display("FAIL read_prio: got %h want %h", bus.rdata, m_hi);
    end
    bus.mfhi = 0; #1;
    vectors++;
    if (bus.rdata !== m_lo) begin
      miscompares++; $display("FAIL read_lo: got %h want %h", bus.rdata, m_lo);
    end
    bus.mflo = 0; #1;
    vectors++;
    if (bus.rdata !== '0) begin
      miscompares++; $display("FAIL read_none: got %h want 0", bus.rdata);
    end
    // Read in the same cycle as start sees the pre-multiply value
    @(negedge clk);
    a = $urandom; b = $urandom;
    bus.start = 1; bus.op_a = a; bus.op_b = b; bus.is_signed = 1; bus.mflo = 1;
    #1;
    vectors++;
    if (bus.rdata !== m_lo || bus.stall !== 1'b0) begin
      miscompares++; $display("FAIL read_at_start: got rdata=%h stall=%b want %h stall=0", bus.rdata, bus.stall, m_lo);
    end
    @(negedge clk);
    bus.start = 0; bus.mflo = 0;
    test_completion("read_at_start", 1, ref_prod(a, b, 1'b1));
  endtask

  task automatic test_directed();
    @(negedge clk); issue('1, '1, 1'b0);
    test_completion("umax_sq", 1, ref_prod('1, '1, 1'b0));
    @(negedge clk); issue('1, 32'h1, 1'b1);
    test_completion("neg1_x_1", 1, ref_prod('1, 32'h1, 1'b1));
    @(negedge clk); issue(32'h8000_0000, 32'h8000_0000, 1'b1);
    test_completion("smin_sq", 1, ref_prod(32'h8000_0000, 32'h8000_0000, 1'b1));
    @(negedge clk); #1;
    vectors++;
    if (bus.done !== 1'b0) begin
      miscompares++; $display("FAIL done_width: got %b want 0", bus.done);
    end
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] a, b;
    logic s;
    for (int n = 0; n < 24; n++) begin
      @(negedge clk);
      a = pick_operand(); b = pick_operand(); s = 1'($urandom);
      issue(a, b, s);
      test_completion("random", 1, ref_prod(a, b, s));
    end
  endtask

  task automatic test_hazard();
    logic [WIDTH-1:0] a, b;
    logic [2*WIDTH-1:0] p;
    int n;
    @(negedge clk);
    a = $urandom; b = $urandom; p = ref_prod(a, b, 1'b0);
    issue(a, b, 1'b0);
    repeat (4) @(negedge clk);
    bus.mflo = 1;
    for (n = 0; n < 40; n++) begin
      #1;
      if (bus.busy !== 1'b1) break;
      vectors++;
      if (bus.stall !== 1'b1 || bus.rdata !== m_lo) begin
        miscompares++; $display("FAIL hazard_stall: got stall=%b rdata=%h want 1 %h", bus.stall, bus.rdata, m_lo);
      end
      @(negedge clk);
    end
    m_hi = p[2*WIDTH-1:WIDTH]; m_lo = p[WIDTH-1:0];
    vectors++;
    if (n >= 40 || n != WIDTH - 3) begin
      miscompares++; $display("FAIL hazard_len: got %0d stalled cycles want %0d", n, WIDTH - 3);
    end
    vectors++;
    if (bus.stall !== 1'b0 || bus.rdata !== m_lo) begin
      miscompares++; $display("FAIL hazard_read: got stall=%b rdata=%h want 0 %h", bus.stall, bus.rdata, m_lo);
    end
    bus.mflo = 0;
  endtask

  task automatic test_collision();
    logic [WIDTH-1:0] a, b;
    logic [2*WIDTH-1:0] p;
    @(negedge clk);
    a = $urandom; b = $urandom; p = ref_prod(a, b, 1'b0);
    if (p[2*WIDTH-1:WIDTH] == 32'h1234) a = a ^ 32'h1;
    p = ref_prod(a, b, 1'b0);
    bus.mthi = 1; bus.wdata = 32'h1234;
    issue(a, b, 1'b0);
    bus.mthi = 0;
    #1;
    vectors++;
    if (bus.hi === 32'h1234 || bus.hi !== m_hi) begin
      miscompares++; $display("FAIL collide_hi: got %h want %h", bus.hi, m_hi);
    end
    @(negedge clk);
    // Second start and a move while running: ignored but stalled
    bus.start = 1; bus.op_a = $urandom; bus.op_b = $urandom; bus.mthi = 1;
    #1;
    vectors++;
    if (bus.stall !== 1'b1 || bus.busy !== 1'b1) begin
      miscompares++; $display("FAIL collide_restart: got stall=%b busy=%b want 1 1", bus.stall, bus.busy);
    end
    @(negedge clk);
    bus.start = 0; bus.mthi = 0;
    test_completion("collide", 3, p);
    vectors++;
    if (bus.hi === 32'h1234) begin
      miscompares++; $display("FAIL collide_final: got %h want not 00001234", bus.hi);
    end
  endtask

  task automatic test_abort();
    @(negedge clk);
    bus.mthi = 1; bus.mtlo = 1; bus.wdata = 32'hA5A5_A5A5;
    @(negedge clk);
    bus.mthi = 0; bus.mtlo = 0; m_hi = 32'hA5A5_A5A5; m_lo = 32'hA5A5_A5A5;
    issue($urandom, $urandom, 1'b0);
    repeat (9) @(negedge clk);
    bus.mflo = 1; rst_n = 1'b0;
    #1;
    m_hi = '0; m_lo = '0;
    vectors++;
    if (bus.busy !== 0 || bus.stall !== 0 || bus.done !== 0) begin
      miscompares++; $display("FAIL abort_status: got busy=%b stall=%b done=%b want 0", bus.busy, bus.stall, bus.done);
    end
    vectors++;
    if (bus.hi !== '0 || bus.lo !== '0 || bus.rdata !== '0) begin
      miscompares++; $display("FAIL abort_regs: got %h_%h rdata=%h want 0", bus.hi, bus.lo, bus.rdata);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1; bus.mflo = 0;
    issue(32'd3, 32'd5, 1'b0);
    test_completion("abort_3x5", 1, ref_prod(32'd3, 32'd5, 1'b0));
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] a, b;
    @(negedge clk);
    a = pick_operand(); b = pick_operand();
    issue(a, b, 1'b1);
    test_completion("b2b_first", 1, ref_prod(a, b, 1'b1));
    a = pick_operand(); b = pick_operand();
    bus.start = 1; bus.op_a = a; bus.op_b = b; bus.is_signed = 1'b0;
    #1;
    vectors++;
    if (bus.stall !== 1'b0) begin
      miscompares++; $display("FAIL b2b_stall: got %b want 0", bus.stall);
    end
    @(negedge clk);
    bus.start = 0;
    test_completion("b2b_second", 1, ref_prod(a, b, 1'b0));
  endtask

  initial begin
    test_reset();
    test_moves();
    test_directed();
    test_random();
    test_hazard();
    test_collision();
    test_abort();
    test_back_to_back();
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/mult_sequencer.md
MULT_SEQUENCER -- requirements
Module: mult_sequencer

Interface
REQ-001 Parameter: WIDTH, 32, operand width (>=2); HI/LO each WIDTH bits.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-004 start  input  1  issue multiply (MULT/MULTU).
REQ-005 is_signed  input  1  sampled with start: 1 = two's-complement, 0 = unsigned.
REQ-006 op_a, op_b  input  WIDTH each  multiplicand and multiplier, sampled with start.
REQ-007 mfhi, mflo  input  1 each  read request for HI or LO.
REQ-008 mthi, mtlo  input  1 each  write request for HI or LO.
REQ-009 wdata  input  WIDTH  data for mthi/mtlo.
REQ-010 rdata  output  WIDTH  read result, combinational.
REQ-011 busy  output  1  high while a multiply is in progress.
REQ-012 stall  output  1  datapath must hold PC and instruction.
REQ-013 done  output  1  one-cycle registered pulse after HI/LO update.
REQ-014 hi, lo  output  WIDTH each  current HI/LO register contents.

Function
REQ-015 FSM states SHALL be IDLE, RUN, FIN; busy = (state != IDLE).
REQ-016 IDLE: start=1 at edge k SHALL latch operand magnitudes (|x| if is_signed, else raw), result sign = is_signed & (a[MSB]^b[MSB]), clear the 2*WIDTH accumulator and iteration counter, and move to RUN.
REQ-017 RUN SHALL perform one shift-add iteration per cycle; after exactly WIDTH iterations (edge k+WIDTH) it SHALL move to FIN.
REQ-018 FIN at edge k+WIDTH+1 SHALL write the accumulator, negated to 2*WIDTH bits if the sign flag is set, to {hi,lo}, and SHALL return to IDLE.
REQ-019 done SHALL be 1 exactly for the cycle following the FIN->IDLE edge, else 0.
REQ-020 Latency: busy high for exactly WIDTH+1 cycles; new HI/LO visible WIDTH+1 cycles after the start edge.
REQ-021 The magnitude of the most negative value (e.g. 0x80000000) SHALL be treated as unsigned 2^(WIDTH-1), with no overflow.
REQ-022 rdata SHALL be hi if mfhi=1, else lo if mflo=1, else 0; mfhi has priority when both are asserted.
REQ-023 stall SHALL be busy & (start | mfhi | mflo | mthi | mtlo); it SHALL be 0 whenever busy=0.
REQ-024 start, mthi and mtlo while busy SHALL be ignored; the requester is held by stall.
REQ-025 In IDLE, mthi/mtlo SHALL write wdata to hi/lo at the clock edge; if start is asserted in the same cycle, start SHALL win and the write SHALL be dropped.
REQ-026 In IDLE, a read in the same cycle as start SHALL return the pre-multiply value with stall=0.
REQ-027 start SHALL be accepted in the cycle done=1; this back-to-back operation SHALL have no idle gap.
REQ-028 Operands SHALL be sampled only at the accept edge; later changes to op_a/op_b SHALL not affect the result.

Reset
REQ-029 With reset=0, the block SHALL asynchronously force state=IDLE, hi=lo=0, accumulator=0, counter=0, done=0, busy=0, stall=0.
REQ-030 Reset during RUN or FIN SHALL abort the operation with no HI/LO write; the block SHALL accept start on the first edge after release.

Verification
REQ-031 Unsigned: op_a=op_b=0xFFFFFFFF, is_signed=0 -> after 33 cycles hi=0xFFFFFFFE, lo=0x00000001, with one done pulse.
REQ-032 Signed: op_a=0xFFFFFFFF (-1), op_b=0x00000001 -> hi=lo=0xFFFFFFFF. Also op_a=op_b=0x80000000 -> hi=0x40000000, lo=0.
REQ-033 Hazard: mflo issued 5 cycles after start -> stall=1 until busy drops; then rdata = new lo and stall=0.
REQ-034 Collision: start and mthi (wdata=0x1234) in the same IDLE cycle -> multiply runs and hi never equals 0x1234. Second start during RUN -> ignored, stall=1.
REQ-035 Abort: reset pulled low at RUN cycle 10 -> busy=0 and hi=lo=0 immediately; after release, 3*5 -> lo=15 after 33 cycles.
REQ-036 Back-to-back: start on the done cycle -> busy stays low for 0 cycles between ops; second result is correct.
